// File: rtl/fp_multiplier_stream_if.sv
// fp_multiplier_stream_if: valid/ready input and output streams plus overflow status of fp_multiplier_stream.
interface fp_multiplier_stream_if #(
    parameter int WI1 = 3,
    parameter int WF1 = 4,
    parameter int WI2 = 4,
    parameter int WF2 = 3,
    parameter int WIO = 4,
    parameter int WFO = 4
);
    logic inValid, inReady, rndMode, satEn;
    logic outValid, outReady, overFlow, clrOvf, stickyOvf;
    logic signed [WI1+WF1-1:0] in1;
    logic signed [WI2+WF2-1:0] in2;
    logic [WIO+WFO-1:0] mulOut;
    modport master (
        output inValid, in1, in2, rndMode, satEn, outReady, clrOvf,
        input inReady, outValid, mulOut, overFlow, stickyOvf
    );
    modport slave (
        input inValid, in1, in2, rndMode, satEn, outReady, clrOvf,
        output inReady, outValid, mulOut, overFlow, stickyOvf
    );
endinterface

// File: rtl/fp_multiplier_stream.sv
// fp_multiplier_stream: signed fixed-point multiply with rounding/saturation at the input,
// followed by a LATENCY-deep stallable pipeline and a sticky overflow flag.
module fp_multiplier_stream #(
    parameter int WI1 = 3,
    parameter int WF1 = 4,
    parameter int WI2 = 4,
    parameter int WF2 = 3,
    parameter int WIO = 4,
    parameter int WFO = 4,
    parameter int LATENCY = 3
) (
    input logic clk,
    input logic rst,
    fp_multiplier_stream_if.slave s
);
    localparam int WP = WI1 + WF1 + WI2 + WF2;
    localparam int FP = WF1 + WF2;
    localparam int WO = WIO + WFO;
    localparam int PAD = (WFO > FP) ? WFO - FP : 0;
    localparam int D = (FP > WFO) ? FP - WFO : 0;
    localparam int WW = WP + 1 + PAD;
    localparam logic signed [WW-1:0] HALF = WW'((1 << D) >> 1);
    localparam logic [WO-1:0] MAXV = {1'b0, {(WO-1){1'b1}}};
    logic signed [WP-1:0] p;
    logic signed [WW-1:0] ext, bias, q;
    logic [WO-1:0] res;
    logic ovf, sticky;
    assign p = WP'(s.in1) * WP'(s.in2);
    assign ext = WW'(p);
    assign bias = s.rndMode ? HALF : '0;
    // one spare MSB absorbs the rounding carry, so the add never wraps
    assign q = ((ext + bias) >>> D) <<< PAD;
    if (WW <= WO) begin : g_fit
        assign res = WO'(q);
        assign ovf = 1'b0;
    end else begin : g_clip
        logic [WW-WO:0] top;
        assign top = q[WW-1:WO-1];
        assign ovf = !(&top || !(|top));
        assign res = (ovf && s.satEn) ? (q[WW-1] ? ~MAXV : MAXV) : q[WO-1:0];
    end
    if (LATENCY == 0) begin : g_comb
        assign s.outValid = s.inValid;
        assign s.inReady = s.outReady;
        assign s.mulOut = res;
        assign s.overFlow = ovf;
    end else begin : g_pipe
        logic [LATENCY-1:0] vld, ov;
        logic [WO-1:0] dat [LATENCY];
        logic adv;
        // whole pipeline moves together; bubbles are kept to preserve fixed latency
        assign adv = !vld[LATENCY-1] || s.outReady;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld <= '0;
                ov <= '0;
                for (int i = 0; i < LATENCY; i++) dat[i] <= '0;
            end else if (adv) begin
                vld[0] <= s.inValid;
                ov[0] <= ovf;
                dat[0] <= res;
                for (int i = 1; i < LATENCY; i++) begin
                    vld[i] <= vld[i-1];
                    ov[i] <= ov[i-1];
                    dat[i] <= dat[i-1];
                end
            end
        end
        assign s.inReady = adv;
        assign s.outValid = vld[LATENCY-1];
        assign s.mulOut = dat[LATENCY-1];
        assign s.overFlow = ov[LATENCY-1];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sticky <= 1'b0;
        else sticky <= (s.outValid && s.outReady && s.overFlow) || (sticky && !s.clrOvf);
    end
    assign s.stickyOvf = sticky;
endmodule
